// File: rtl/transpose_buf_8x8.sv
// Ping-pong 8x8 transpose buffer between the row-pass and column-pass 1-D DCT.
// Rows are written into one bank while the other bank is drained column by column.
module transpose_buf_8x8 #(
  parameter int DATA_WIDTH = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] in_data  [0:7],
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] out_data [0:7],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last
);

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e     state_q, state_d;
  logic [2:0] wr_row_q, wr_row_d;
  logic [2:0] rd_col_q, rd_col_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [1:0] full_q, full_d;
  logic       row_acc, col_acc, row_last, col_last;

  logic signed [DATA_WIDTH-1:0] mem_q [0:1][0:7][0:7];

  // Handshakes, pointer/flag updates and read FSM next state
  always_comb begin
    in_ready  = !full_q[wr_bank_q];
    out_valid = (state_q == DRAIN);
    out_last  = out_valid && (rd_col_q == 3'd7);
    row_acc   = in_valid && in_ready;
    col_acc   = out_valid && out_ready;
    row_last  = row_acc && (wr_row_q == 3'd7);
    col_last  = col_acc && (rd_col_q == 3'd7);

    wr_row_d  = wr_row_q;
    rd_col_d  = rd_col_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    state_d   = state_q;

    if (row_acc) wr_row_d = wr_row_q + 3'd1;
    if (row_last) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
    end
    if (col_acc) rd_col_d = rd_col_q + 3'd1;
    if (col_last) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end

    // full_d lets a bank completed on this same edge start draining without a bubble
    case (state_q)
      IDLE:    if (full_d[rd_bank_q]) state_d = DRAIN;
      DRAIN:   if (col_last && !full_d[!rd_bank_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      out_data[k] = mem_q[rd_bank_q][k][rd_col_q];
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_row_q  <= 3'd0;
      rd_col_q  <= 3'd0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      wr_row_q  <= wr_row_d;
      rd_col_q  <= rd_col_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
    end
  end

  // Bank storage, unaffected by reset
  always_ff @(posedge clk) begin
    if (row_acc) begin
      for (int c = 0; c < 8; c++) begin
        mem_q[wr_bank_q][wr_row_q][c] <= in_data[c];
      end
    end
  end

endmodule
